// File: rtl/vend_change_dispenser.sv
// Change dispenser: issues dimes/nickels to the hopper one at a time
// under a valid/ack handshake and reports done, refund and faults.
module vend_change_dispenser #(
  parameter int CW      = 6,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] credit,
  input  logic [CW-1:0] price,
  input  logic          coin_ack,
  input  logic          dime_empty,
  input  logic          nickel_empty,
  output logic [1:0]    coin_out,
  output logic          busy,
  output logic          done,
  output logic          refund,
  output logic          fault,
  output logic [CW-1:0] remaining
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TWO = CW'(2);
  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_NICK = 2'b01;
  localparam logic [1:0] C_DIME = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [1:0]    coin_n;
  logic          busy_n;
  logic          done_n;
  logic          refund_n;
  logic          fault_n;
  logic [CW-1:0] rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      coin_out  <= C_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      refund    <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      coin_out  <= coin_n;
      busy      <= busy_n;
      done      <= done_n;
      refund    <= refund_n;
      fault     <= fault_n;
      remaining <= rem_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    coin_n   = coin_out;
    busy_n   = busy;
    done_n   = 1'b0;
    refund_n = refund;
    fault_n  = fault;
    rem_n    = remaining;
    unique case (state)
      S_IDLE: begin
        coin_n = C_NONE;
        if (start) begin
          rem_n    = (credit >= price) ? credit - price : credit;
          refund_n = (credit < price);
          busy_n   = 1'b1;
          state_n  = S_SELECT;
        end
      end
      S_SELECT: begin
        coin_n = C_NONE;
        cnt_n  = '0;
        if (remaining == '0) begin
          state_n = S_DONE;
        end else if (remaining >= TWO && !dime_empty) begin
          coin_n  = C_DIME;
          state_n = S_ISSUE;
        end else if (!nickel_empty) begin
          coin_n  = C_NICK;
          state_n = S_ISSUE;
        end else begin
          fault_n = 1'b1;
          busy_n  = 1'b0;
          state_n = S_FAULT;
        end
      end
      S_ISSUE: begin
        // an ack on the final timeout cycle still counts as delivered
        if (coin_ack) begin
          rem_n   = remaining - ((coin_out == C_DIME) ? TWO : ONE);
          coin_n  = C_NONE;
          state_n = S_GAP;
        end else if (cnt == TLAST) begin
          coin_n  = C_NONE;
          fault_n = 1'b1;
          busy_n  = 1'b0;
          state_n = S_FAULT;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      S_GAP: begin
        coin_n  = C_NONE;
        state_n = S_SELECT;
      end
      S_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      S_FAULT: begin
        coin_n  = C_NONE;
        busy_n  = 1'b0;
        fault_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
Change/refund issuing controller that sits on the output side of the coin-accepting vending FSM. On a start pulse it computes the change owed from accumulated credit and item price. It then drives the same 2-bit coin code outward, one coin at a time, to a coin hopper under a valid/ack handshake. It reports completion, refund status and hopper faults back to the vend controller.

Parameters:
CW, 6, width of credit/price/remaining; all amounts in nickel units (1 = 5c, 2 = 10c)
TIMEOUT, 16, cycles a coin may be presented without coin_ack before fault (must be >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle request; sampled only in IDLE
credit  in  CW  accumulated credit, nickel units, sampled with start
price  in  CW  item price, nickel units, sampled with start
coin_ack  in  1  hopper accepted the presented coin
dime_empty  in  1  hopper has no dimes
nickel_empty  in  1  hopper has no nickels
coin_out  out  2  coin code: 00 none, 01 nickel, 10 dime; 11 never driven
busy  out  1  high from start acceptance until DONE/FAULT
done  out  1  one-cycle pulse: all change issued
refund  out  1  latched at start: credit < price (full credit refunded)
fault  out  1  sticky hopper/timeout fault
remaining  out  CW  nickel units still owed

Behaviour:
- All outputs registered. Reset: state IDLE, coin_out=00, busy=0, done=0, refund=0, fault=0, remaining=0, timeout counter=0. Reset mid-dispense aborts immediately; coin_out=00 after the reset edge.
- States: IDLE, SELECT, ISSUE, GAP, DONE, FAULT.
- IDLE: edge with start=1 -> remaining = (credit>=price) ? credit-price : credit; refund = (credit<price); busy=1; -> SELECT. start=0 -> stay; done deasserts.
- SELECT (coin_out=00):
  - remaining==0 -> DONE.
  - remaining>=2 and !dime_empty -> coin_out=10, -> ISSUE.
  - else remaining>=1 and !nickel_empty -> coin_out=01, -> ISSUE.
  - else -> FAULT.
  - Greedy: dimes first; falls back to nickels when dimes are empty.
- ISSUE: coin_out held stable. Timeout counter clears on entry and increments each cycle without ack.
  - Edge with coin_ack=1 -> remaining -= 2 (dime) or 1 (nickel); coin_out=00; -> GAP.
  - Counter reaching TIMEOUT-1 without ack -> FAULT with coin_out=00; remaining unchanged.
  - If coin_ack=1 on the same edge as the counter hits TIMEOUT-1, the ack wins.
- GAP: one cycle with coin_out=00 (hopper inter-coin spacing) -> SELECT. coin_ack is ignored in GAP/SELECT/IDLE.
- DONE: done=1 for exactly one cycle; busy=0; -> IDLE. refund stays valid until the next accepted start.
- FAULT: fault=1, busy=0, coin_out=00, remaining frozen at the undispensed amount. start is ignored; only rst exits.
- start while busy: ignored; no relatch.
- Timing with immediate ack: start edge k, coin_out valid after edge k+1, ack sampled edge k+2, next coin after edge k+4. Minimum 3 cycles per coin.
- Arithmetic: subtraction never underflows (dime only when remaining>=2). credit-price is computed at CW bits, guarded by the compare.
- Zero change (credit==price): SELECT -> DONE; no coin driven; done at edge k+2.

Test Plan:
- credit=6, price=3, ack tied 1 -> coin_out 10 then 01, each high 1 cycle, separated by 2 cycles of 00; remaining 3->1->0; done pulse once; refund=0.
- credit=2, price=5 -> refund=1, one dime issued, remaining 2->0, done.
- credit=4, price=4 -> no coin_out activity; done one cycle after SELECT; busy high 2 cycles.
- credit=5, price=0, dime_empty=1 -> five nickels (01); remaining 5->0; then set nickel_empty=1 with credit=1 -> fault=1, remaining=1, busy=0; start ignored until rst.
- credit=2, price=0, coin_ack held 0 -> coin_out=10 for TIMEOUT cycles, then fault=1, coin_out=00, remaining=2; rst clears all outputs.
- rst asserted while coin_out=10 -> next cycle all outputs at reset values; a new start behaves normally.
